bin_bcd_conv: RTL and testbench

Upstream stage of the 4-digit seven-segment visualiser: converts the synchronised switch value `SW` from binary to packed BCD and presents it as the 16-bit `dat` word the display stage consumes. The conversion is sequential double-dabble: one adjust-and-shift iteration per clock. A new conversion starts whenever the switch value changes. The block runs on the board's 50 MHz clock and is reset by the board button.

---
 rtl/vis_pkg.sv | 24 ++
 rtl/bcd_step.sv | 22 ++
 rtl/bin_bcd_conv.sv | 119 +++++++++++
 tb/tb_bin_bcd_conv.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vis_pkg.sv
// Shared types and helpers for the seven-segment visualiser pipeline.
package vis_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int DAT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Double-dabble digit correction; input is at most 9 so 4 bits never overflow.
    function automatic logic [3:0] bcd_adj(input logic [3:0] nibble);
        logic [3:0] res;
        if (nibble >= 4'd5) begin
            res = nibble + 4'd3;
        end else begin
            res = nibble;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// One combinational double-dabble iteration: adjust every BCD digit, then shift left by one.
module bcd_step
    import vis_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [DAT_W+IN_W-1:0] sh_in,
    output logic [DAT_W+IN_W-1:0] sh_out
);

    logic [DAT_W+IN_W-1:0] adj_s;

    // Adjust the BCD nibbles in the upper field, leave the binary field alone, then shift.
    always_comb begin
        adj_s = sh_in;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj_s[IN_W+4*i +: 4] = bcd_adj(sh_in[IN_W+4*i +: 4]);
        end
        sh_out = adj_s << 1;
    end

endmodule

// File: rtl/bin_bcd_conv.sv
// Sequential binary-to-BCD converter: synchronises SW and re-converts it whenever it changes.
module bin_bcd_conv
    import vis_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic                 F50MHz,
    input  logic                 BTN0,
    input  logic [IN_W-1:0]      SW,
    output logic [DAT_W-1:0]     dat,
    output logic                 dat_vld,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_W - 1);

    logic [IN_W-1:0]        sw_meta_r;
    logic [IN_W-1:0]        sw_sync_r;
    logic [IN_W-1:0]        src_r;
    logic [DAT_W+IN_W-1:0]  sh_r;
    logic [DAT_W+IN_W-1:0]  sh_step_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   pend_r;
    conv_state_t            state_r;
    conv_state_t            state_nxt_s;
    logic                   load_s;
    logic                   shift_s;
    logic                   done_s;

    bcd_step #(
        .IN_W (IN_W)
    ) u_step (
        .sh_in  (sh_r),
        .sh_out (sh_step_s)
    );

    // Two-stage synchroniser for the asynchronous switch inputs.
    always_ff @(posedge F50MHz or posedge BTN0) begin
        if (BTN0) begin
            sw_meta_r <= {IN_W{1'b0}};
            sw_sync_r <= {IN_W{1'b0}};
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
        end
    end

    // State register.
    always_ff @(posedge F50MHz or posedge BTN0) begin
        if (BTN0) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath control; pend forces one conversion after reset.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if ((sw_sync_r != src_r) || pend_r) begin
                    load_s      = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                done_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Conversion datapath and registered result.
    always_ff @(posedge F50MHz or posedge BTN0) begin
        if (BTN0) begin
            src_r   <= {IN_W{1'b0}};
            sh_r    <= {(DAT_W+IN_W){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= 1'b1;
            dat     <= {DAT_W{1'b0}};
            dat_vld <= 1'b0;
        end else begin
            dat_vld <= done_s;
            if (load_s) begin
                src_r  <= sw_sync_r;
                sh_r   <= {{DAT_W{1'b0}}, sw_sync_r};
                cnt_r  <= {CNT_W{1'b0}};
                pend_r <= 1'b0;
            end else if (shift_s) begin
                sh_r  <= sh_step_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (done_s) begin
                dat <= sh_r[DAT_W+IN_W-1:IN_W];
            end
        end
    end

    assign busy = (state_r == SHIFT) || (state_r == DONE);

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Self-checking bench for bin_bcd_conv at IN_W=8 and IN_W=13.
module tb_bin_bcd_conv;

    logic        clk;
    logic        rst;
    logic [7:0]  sw8;
    logic [15:0] dat8;
    logic        vld8;
    logic        busy8;
    logic [12:0] sw13;
    logic [15:0] dat13;
    logic        vld13;
    logic        busy13;

    int errors = 0;
    int checks = 0;

    bin_bcd_conv #(.IN_W(8)) u8 (
        .F50MHz (clk), .BTN0 (rst), .SW (sw8),
        .dat (dat8), .dat_vld (vld8), .busy (busy8)
    );

    bin_bcd_conv #(.IN_W(13)) u13 (
        .F50MHz (clk), .BTN0 (rst), .SW (sw13),
        .dat (dat13), .dat_vld (vld13), .busy (busy13)
    );

    initial begin
        clk = 1'b0;
        #5;
        forever #10 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  sw;
        logic [15:0] exp_dat;
    } vec_t;

    function automatic logic [15:0] bcd_ref(input int v);
        logic [15:0] r;
        int          t;
        r = 16'h0000;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // lat counts edges after the first edge that samples the new SW (that edge is 0).
    task automatic wait_vld(input bit sel13, input int bound, output int lat, output logic [15:0] d);
        lat = -1;
        d   = 16'h0000;
        for (int i = 0; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (sel13 ? vld13 : vld8) begin
                lat = i;
                d   = sel13 ? dat13 : dat8;
                return;
            end
        end
    endtask

    vec_t        vecs[7];
    int          lat;
    logic [15:0] d;
    int          pulses;
    int          extra;
    int          p1, p2;
    logic [15:0] d1, d2;
    int          low_run, max_low;
    bit          seen_busy;
    int          busy_cnt;
    logic [15:0] prev;
    logic [7:0]  v8;
    logic [12:0] v13;

    initial begin
        vecs[0] = '{8'h01, 16'h0001};
        vecs[1] = '{8'h02, 16'h0002};
        vecs[2] = '{8'h09, 16'h0009};
        vecs[3] = '{8'h10, 16'h0016};
        vecs[4] = '{8'h1A, 16'h0026};
        vecs[5] = '{8'h1F, 16'h0031};
        vecs[6] = '{8'hFF, 16'h0255};

        // Power-on reset
        rst  = 1'b1;
        sw8  = 8'h00;
        sw13 = 13'h0000;
        #50;
        chk("rst_dat", 32'(dat8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_vld", 32'(vld8), 32'h0);
        #40;
        rst = 1'b0;
        pulses = 0;
        d = 16'hFFFF;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (vld8) begin
                pulses++;
                d = dat8;
            end
        end
        chk("rst_pulses", 32'(pulses), 32'd1);
        chk("rst_first_dat", 32'(d), 32'h0);

        // Basic conversions
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            sw8 = vecs[k].sw;
            wait_vld(1'b0, 30, lat, d);
            chk("basic_lat", 32'(lat), 32'd11);
            chk("basic_dat", 32'(d), 32'(vecs[k].exp_dat));
            extra = 0;
            for (int i = lat + 1; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (vld8) extra++;
            end
            chk("basic_single_pulse", 32'(extra), 32'd0);
        end

        // Change during conversion
        @(negedge clk);
        sw8 = 8'h01;
        p1 = -1; p2 = -1; d1 = 16'hFFFF; d2 = 16'hFFFF;
        low_run = 0; max_low = 0; seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (vld8) begin
                if (p1 < 0) begin
                    p1 = i; d1 = dat8;
                end else if (p2 < 0) begin
                    p2 = i; d2 = dat8;
                end
            end
            if (busy8) begin
                seen_busy = 1'b1;
                low_run = 0;
            end else if (seen_busy && p2 < 0) begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end
            if (i == 2) begin
                @(negedge clk);
                sw8 = 8'h02;
            end
        end
        chk("chg_first_dat", 32'(d1), 32'h0001);
        chk("chg_second_dat", 32'(d2), 32'h0002);
        chk("chg_first_lat", 32'(p1), 32'd11);
        chk("chg_spacing", 32'(p2 - p1), 32'd10);
        chk("chg_busy_gap_le1", 32'(max_low <= 1), 32'd1);

        // Stable input
        prev = dat8;
        pulses = 0; busy_cnt = 0; extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (vld8) pulses++;
            if (busy8) busy_cnt++;
            if (dat8 !== prev) extra++;
        end
        chk("stable_vld", 32'(pulses), 32'd0);
        chk("stable_busy", 32'(busy_cnt), 32'd0);
        chk("stable_dat_changes", 32'(extra), 32'd0);
        chk("stable_dat", 32'(dat8), 32'h0002);

        // Reset mid-conversion
        @(negedge clk);
        sw8 = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy_before", 32'(busy8), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_dat", 32'(dat8), 32'h0);
        chk("midrst_busy", 32'(busy8), 32'h0);
        chk("midrst_vld", 32'(vld8), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_vld(1'b0, 40, lat, d);
        chk("midrst_first_ok", 32'(lat >= 0), 32'd1);
        chk("midrst_first_dat", 32'(d), 32'h0);
        wait_vld(1'b0, 40, lat, d);
        chk("midrst_second_ok", 32'(lat >= 0), 32'd1);
        chk("midrst_second_dat", 32'(d), 32'h0085);
        repeat (10) @(posedge clk);

        // IN_W=13 sweep
        @(negedge clk);
        sw13 = 13'd8191;
        wait_vld(1'b1, 40, lat, d);
        chk("w13_8191_lat", 32'(lat), 32'd16);
        chk("w13_8191_dat", 32'(d), 32'h8191);
        repeat (5) @(posedge clk);
        @(negedge clk);
        sw13 = 13'd1000;
        wait_vld(1'b1, 40, lat, d);
        chk("w13_1000_lat", 32'(lat), 32'd16);
        chk("w13_1000_dat", 32'(d), 32'h1000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        sw13 = 13'd0;
        wait_vld(1'b1, 40, lat, d);
        chk("w13_0_lat", 32'(lat), 32'd16);
        chk("w13_0_dat", 32'(d), 32'h0000);

        // Randomised values against the arithmetic reference
        for (int k = 0; k < 40; k++) begin
            v8 = 8'($urandom_range(0, 255));
            if (v8 == sw8) v8 = v8 + 8'd1;
            @(negedge clk);
            sw8 = v8;
            wait_vld(1'b0, 30, lat, d);
            chk("rand8_lat", 32'(lat), 32'd11);
            chk("rand8_dat", 32'(d), 32'(bcd_ref(int'(v8))));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            v13 = 13'($urandom_range(0, 8191));
            if (v13 == sw13) v13 = v13 ^ 13'd1;
            @(negedge clk);
            sw13 = v13;
            wait_vld(1'b1, 40, lat, d);
            chk("rand13_lat", 32'(lat), 32'd16);
            chk("rand13_dat", 32'(d), 32'(bcd_ref(int'(v13))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
